// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline definitions: register-index width, forwarding
// select encodings, hazard-unit FSM states and the forwarding selector.
package rv32i_pkg;

  localparam int unsigned REG_AW = 5;

  // ALU operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } hz_state_e;

  // Operand source for one execute-stage register; x0 is never forwarded
  // and the younger memory-stage result beats writeback.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rd_m,
    input logic              we_m,
    input logic [REG_AW-1:0] rd_w,
    input logic              we_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if ((rs != '0) && we_m && (rs == rd_m)) begin
      sel = FWD_MEM;
    end else if ((rs != '0) && we_w && (rs == rd_w)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage : rv32i_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : clock
//   rst_n : asynchronous active-low reset (count -> 0)
//   clr   : synchronous clear, beats inc
//   inc   : increment enable; holds once count reaches MAX
//   count : current value
module sat_counter #(
  parameter int unsigned   W   = 8,
  parameter logic [W-1:0]  MAX = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + W'(1);
    end
  end

endmodule : sat_counter

// File: rtl/pipeline_hazard_unit.sv
// Hazard and control unit for the RV32I 5-stage pipeline.
//   i_clk, i_rstn          : clock, asynchronous active-low reset
//   Rs1D/Rs2D              : decode source registers
//   Rs1E/Rs2E/RdE          : execute source/destination registers
//   RdM/RdW, RegWriteM/W   : later-stage destinations and write enables
//   ResultSrcE0            : execute instruction is a load
//   PCSrcE                 : taken branch/jump resolved in execute
//   MemReqM/MemReadyM      : data-memory handshake in the memory stage
//   Stall*/Flush*/Forward* : combinational pipeline controls (0 in reset)
//   o_busy                 : registered, FSM in MEM_WAIT
//   o_mem_timeout          : sticky, wait exceeded MEM_TIMEOUT cycles
//   o_stall_cnt/o_flush_cnt: saturating load-use stall / flush counters
module pipeline_hazard_unit
  import rv32i_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              ResultSrcE0,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              PCSrcE,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              o_busy,
  output logic              o_mem_timeout,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic              lw_stall_c;
  logic              mem_stall_c;
  logic              stall_inc_c;
  logic              flush_inc_c;
  logic [WAIT_W-1:0] wait_cnt;
  hz_state_e         state;

  // Hazard terms
  assign lw_stall_c  = ResultSrcE0 && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));
  assign mem_stall_c = MemReqM && !MemReadyM;

  // A pending branch or load-use is frozen during a memory wait and is
  // only counted on the cycle it actually takes effect.
  assign stall_inc_c = lw_stall_c && !PCSrcE && !mem_stall_c;
  assign flush_inc_c = PCSrcE && !mem_stall_c;

  // Pipeline controls; reset forces every control low asynchronously.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (i_rstn) begin
      ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
      if (mem_stall_c) begin
        // Freeze F..M and bubble writeback until memory responds
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        // Taken branch wins over load-use: PC loads the target, D flushes
        StallF = lw_stall_c && !PCSrcE;
        StallD = lw_stall_c && !PCSrcE;
        FlushD = PCSrcE;
        FlushE = lw_stall_c || PCSrcE;
      end
    end
  end

  // Wait-state FSM with registered busy flag
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state  <= ST_RUN;
      o_busy <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_stall_c) begin
            state  <= ST_MEM_WAIT;
            o_busy <= 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          // Ready completes the wait; dropping the request aborts it
          if (MemReadyM || !MemReqM) begin
            state  <= ST_RUN;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= ST_RUN;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  // Consecutive wait cycles, saturating at MEM_TIMEOUT
  sat_counter #(
    .W   (WAIT_W),
    .MAX (WAIT_MAX)
  ) u_wait_cnt (
    .clk   (i_clk),
    .rst_n (i_rstn),
    .clr   (!mem_stall_c),
    .inc   (mem_stall_c),
    .count (wait_cnt)
  );

  // Sticky timeout, set on the edge the wait count reaches MEM_TIMEOUT
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_mem_timeout <= 1'b0;
    end else if (mem_stall_c && (wait_cnt == WAIT_LAST)) begin
      o_mem_timeout <= 1'b1;
    end
  end

  // Performance counters
  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (i_clk),
    .rst_n (i_rstn),
    .clr   (1'b0),
    .inc   (stall_inc_c),
    .count (o_stall_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_flush_cnt (
    .clk   (i_clk),
    .rst_n (i_rstn),
    .clr   (1'b0),
    .inc   (flush_inc_c),
    .count (o_flush_cnt)
  );

endmodule : pipeline_hazard_unit

// File: tb/tb_pipeline_hazard_unit.sv
// Scoreboard bench for pipeline_hazard_unit (MEM_TIMEOUT=8, CNT_W=4).
module tb_pipeline_hazard_unit;

  typedef struct packed {
    logic [3:0] stall;   // {F,D,E,M}
    logic [2:0] flush;   // {D,E,W}
    logic [1:0] fa;
    logic [1:0] fb;
    logic       busy;
    logic       tmo;
    logic [3:0] scnt;
    logic [3:0] fcnt;
  } out_t;

  typedef struct {
    string name;
    out_t  exp;
  } sb_t;

  logic       clk;
  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic       o_busy, o_mem_timeout;
  logic [3:0] o_stall_cnt, o_flush_cnt;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  pipeline_hazard_unit #(
    .MEM_TIMEOUT (8),
    .CNT_W       (4)
  ) dut (
    .i_clk         (clk),
    .i_rstn        (rst_n),
    .Rs1D          (Rs1D),
    .Rs2D          (Rs2D),
    .Rs1E          (Rs1E),
    .Rs2E          (Rs2E),
    .RdE           (RdE),
    .RdM           (RdM),
    .RdW           (RdW),
    .ResultSrcE0   (ResultSrcE0),
    .RegWriteM     (RegWriteM),
    .RegWriteW     (RegWriteW),
    .PCSrcE        (PCSrcE),
    .MemReqM       (MemReqM),
    .MemReadyM     (MemReadyM),
    .StallF        (StallF),
    .StallD        (StallD),
    .StallE        (StallE),
    .StallM        (StallM),
    .FlushD        (FlushD),
    .FlushE        (FlushE),
    .FlushW        (FlushW),
    .ForwardAE     (ForwardAE),
    .ForwardBE     (ForwardBE),
    .o_busy        (o_busy),
    .o_mem_timeout (o_mem_timeout),
    .o_stall_cnt   (o_stall_cnt),
    .o_flush_cnt   (o_flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic out_t mk(input logic [3:0] stall, input logic [2:0] flush,
                              input logic [1:0] fa, input logic [1:0] fb,
                              input logic busy, input logic tmo,
                              input logic [3:0] scnt, input logic [3:0] fcnt);
    out_t o;
    o.stall = stall; o.flush = flush; o.fa = fa; o.fb = fb;
    o.busy = busy; o.tmo = tmo; o.scnt = scnt; o.fcnt = fcnt;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input out_t e);
    sb_t s;
    s.name = name;
    s.exp  = e;
    sb_q.push_back(s);
  endtask

  task automatic clr_in();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
    RdE = '0; RdM = '0; RdW = '0;
    ResultSrcE0 = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
  endtask

  task automatic set_lw();
    ResultSrcE0 = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
  endtask

  // Monitor: outputs are observed mid-cycle, away from the active edge
  initial begin
    sb_t  s;
    out_t got;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        s   = sb_q.pop_front();
        got = mk({StallF, StallD, StallE, StallM}, {FlushD, FlushE, FlushW},
                 ForwardAE, ForwardBE, o_busy, o_mem_timeout, o_stall_cnt, o_flush_cnt);
        n_checks++;
        if (got !== s.exp) begin
          n_fail++;
          $display("FAIL %s: got=%b expected=%b (stall,flush,fa,fb,busy,tmo,scnt,fcnt)",
                   s.name, got, s.exp);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    clr_in();
    // Hazard-causing inputs while in reset must still give all-zero outputs
    set_lw();
    Rs1E = 5'd3; RdM = 5'd3; RegWriteM = 1'b1;
    tick();
    expect_out("reset", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 4'd0, 4'd0));
    tick();
    rst_n = 1'b1;
    clr_in();
    expect_out("idle", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 4'd0, 4'd0));

    // Load-use
    tick(); set_lw();
    expect_out("loaduse_rs1", mk(4'b1100, 3'b010, 2'b00, 2'b00, 0, 0, 4'd0, 4'd0));
    tick(); clr_in();
    expect_out("loaduse_cnt", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 4'd1, 4'd0));
    tick(); ResultSrcE0 = 1'b1; RdE = 5'd0; Rs1D = 5'd0;
    expect_out("loaduse_rd0", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 4'd1, 4'd0));
    tick(); clr_in(); ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7; Rs1D = 5'd1;
    expect_out("loaduse_rs2", mk(4'b1100, 3'b010, 2'b00, 2'b00, 0, 0, 4'd1, 4'd0));
    tick(); clr_in();
    expect_out("loaduse_cnt2", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 4'd2, 4'd0));

    // Forwarding priority
    tick(); Rs1E = 5'd3; Rs2E = 5'd9; RdM = 5'd3; RegWriteM = 1'b1; RdW = 5'd3; RegWriteW = 1'b1;
    expect_out("fwd_mem_prio", mk(4'b0000, 3'b000, 2'b10, 2'b00, 0, 0, 4'd2, 4'd0));
    tick(); RegWriteM = 1'b0;
    expect_out("fwd_wb", mk(4'b0000, 3'b000, 2'b01, 2'b00, 0, 0, 4'd2, 4'd0));
    tick(); RegWriteM = 1'b1; Rs1E = 5'd0; Rs2E = 5'd3;
    expect_out("fwd_x0", mk(4'b0000, 3'b000, 2'b00, 2'b10, 0, 0, 4'd2, 4'd0));
    tick(); Rs1E = 5'd4; RdM = 5'd4; Rs2E = 5'd3;
    expect_out("fwd_split", mk(4'b0000, 3'b000, 2'b10, 2'b01, 0, 0, 4'd2, 4'd0));

    // Branch beats load-use
    tick(); clr_in(); set_lw(); PCSrcE = 1'b1;
    expect_out("branch_vs_lw", mk(4'b0000, 3'b110, 2'b00, 2'b00, 0, 0, 4'd2, 4'd0));
    tick(); clr_in();
    expect_out("branch_cnt", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 4'd2, 4'd1));

    // Memory wait with held branch and load-use
    for (int i = 0; i < 4; i++) begin
      tick(); set_lw(); PCSrcE = 1'b1; MemReqM = 1'b1; MemReadyM = 1'b0;
      expect_out($sformatf("memwait_%0d", i),
                 mk(4'b1111, 3'b001, 2'b00, 2'b00, (i > 0), 0, 4'd2, 4'd1));
    end
    tick(); MemReadyM = 1'b1;
    expect_out("memwait_release", mk(4'b0000, 3'b110, 2'b00, 2'b00, 1, 0, 4'd2, 4'd1));
    tick(); clr_in();
    expect_out("memwait_done", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 4'd2, 4'd2));

    // Timeout after 8 wait edges
    for (int i = 0; i < 8; i++) begin
      tick(); MemReqM = 1'b1; MemReadyM = 1'b0;
      expect_out($sformatf("tmo_wait_%0d", i),
                 mk(4'b1111, 3'b001, 2'b00, 2'b00, (i > 0), 0, 4'd2, 4'd2));
    end
    tick();
    expect_out("tmo_set", mk(4'b1111, 3'b001, 2'b00, 2'b00, 1, 1, 4'd2, 4'd2));
    tick(); MemReadyM = 1'b1;
    expect_out("tmo_ready", mk(4'b0000, 3'b000, 2'b00, 2'b00, 1, 1, 4'd2, 4'd2));
    tick(); clr_in();
    expect_out("tmo_sticky", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 1, 4'd2, 4'd2));

    // Reset in the middle of a wait
    tick(); MemReqM = 1'b1; MemReadyM = 1'b0;
    expect_out("rst_wait_0", mk(4'b1111, 3'b001, 2'b00, 2'b00, 0, 1, 4'd2, 4'd2));
    tick();
    expect_out("rst_wait_1", mk(4'b1111, 3'b001, 2'b00, 2'b00, 1, 1, 4'd2, 4'd2));
    tick(); rst_n = 1'b0;
    expect_out("rst_async", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 4'd0, 4'd0));
    tick(); rst_n = 1'b1; clr_in();
    expect_out("rst_release", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 4'd0, 4'd0));
    tick();
    expect_out("rst_run", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 4'd0, 4'd0));

    // Stall counter saturation at 15
    for (int i = 0; i < 20; i++) begin
      tick(); set_lw();
      expect_out($sformatf("sat_%0d", i),
                 mk(4'b1100, 3'b010, 2'b00, 2'b00, 0, 0, 4'((i > 15) ? 15 : i), 4'd0));
    end
    tick(); clr_in();
    expect_out("sat_hold", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 4'd15, 4'd0));

    // Drain the scoreboard within a bounded number of cycles
    for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(posedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pipeline_hazard_unit
